// File: rtl/npu_pkg.sv
// Shared definitions for the NPU elementwise ALU: widths, opcodes, FSM states
// and the signed 8-bit saturation helper.
package npu_pkg;
    localparam int DATA_W = 8;
    localparam int RAW_W  = 17;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_MAX     = 3'd3;
    localparam logic [2:0] OP_MIN     = 3'd4;
    localparam logic [2:0] OP_RELU    = 3'd5;
    localparam logic [2:0] OP_PASSA   = 3'd6;
    localparam logic [2:0] OP_ABSDIFF = 3'd7;

    localparam logic signed [RAW_W-1:0] SAT_HI = 17'sd127;
    localparam logic signed [RAW_W-1:0] SAT_LO = -17'sd128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic signed [DATA_W-1:0] sat8(input logic signed [RAW_W-1:0] x);
        if (x > SAT_HI) return SAT_HI[DATA_W-1:0];
        if (x < SAT_LO) return SAT_LO[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/npu_ew_op.sv
// First pipeline stage: combinational elementwise op on A/B, registered as a
// 17-bit unsaturated result together with its valid bit.
module npu_ew_op
    import npu_pkg::*;
(
    input  logic                     CLK,
    input  logic                     rst_x,
    input  logic                     acc,
    input  logic [2:0]               op,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     vld_q,
    output logic signed [RAW_W-1:0]  raw_q
);
    logic signed [RAW_W-1:0] ax, bx, diff, res, raw_d;

    always_comb begin
        ax   = {{(RAW_W-DATA_W){a[DATA_W-1]}}, a};
        bx   = {{(RAW_W-DATA_W){b[DATA_W-1]}}, b};
        diff = ax - bx;
        case (op)
            OP_ADD:     res = ax + bx;
            OP_SUB:     res = diff;
            OP_MUL:     res = ax * bx;
            OP_MAX:     res = (ax > bx) ? ax : bx;
            OP_MIN:     res = (ax < bx) ? ax : bx;
            OP_RELU:    res = ax[RAW_W-1] ? '0 : ax;
            OP_PASSA:   res = ax;
            default:    res = diff[RAW_W-1] ? -diff : diff;
        endcase
        raw_d = acc ? res : raw_q;
    end

    always_ff @(posedge CLK or negedge rst_x) begin
        if (!rst_x) begin
            vld_q <= 1'b0;
            raw_q <= '0;
        end else begin
            vld_q <= acc;
            raw_q <= raw_d;
        end
    end
endmodule

// File: rtl/npu_ew_alu.sv
// Elementwise ALU at the tail of the local-memory stream: run FSM, beat
// counters, operand-valid delay line and the shift/saturate output stage.
module npu_ew_alu
    import npu_pkg::*;
#(
    parameter int LEN    = 1024,
    parameter int IN_LAT = 2
) (
    input  logic              CLK,
    input  logic              rst_x,
    input  logic [2:0]        OPCODE,
    input  logic [2:0]        SHIFT,
    input  logic              NPU_EN,
    input  logic [DATA_W-1:0] A_RDATA,
    input  logic [DATA_W-1:0] B_RDATA,
    output logic              LM_EN,
    output logic [DATA_W-1:0] C_WDATA,
    output logic              BUSY,
    output logic              DONE
);
    localparam int               CNT_W  = $clog2(LEN) + 1;
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

    state_e            state_q, state_d;
    logic              en_q;
    logic [IN_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [2:0]        op_q, op_d, shift_q, shift_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, out_cnt_q, out_cnt_d;
    logic              done_q, done_d, lm_en_q, lm_en_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic              in_valid, rise, last_out, start, accept, s1_vld;
    logic signed [RAW_W-1:0] s1_raw, s2_shr;

    assign in_valid = vld_pipe_q[IN_LAT-1];
    assign rise     = NPU_EN & ~en_q;
    assign last_out = lm_en_q && (out_cnt_q == LAST_C);
    // A rise landing on the final write beat chains straight into the next run.
    assign start    = rise && (state_q == ST_IDLE || state_q == ST_DONE ||
                               (state_q == ST_DRAIN && last_out));
    assign accept   = (state_q == ST_RUN) && in_valid && (acc_cnt_q < LEN_C);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        shift_d   = shift_q;
        acc_cnt_d = acc_cnt_q + CNT_W'(accept);
        out_cnt_d = out_cnt_q + CNT_W'(lm_en_q);
        done_d    = done_q;
        case (state_q)
            ST_RUN:   if (accept && acc_cnt_q == LAST_C) state_d = ST_DRAIN;
            ST_DRAIN: if (last_out) begin
                          state_d = ST_DONE;
                          done_d  = 1'b1;
                      end
            default:  ;
        endcase
        if (start) begin
            state_d   = ST_RUN;
            op_d      = OPCODE;
            shift_d   = SHIFT;
            acc_cnt_d = '0;
            out_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    always_comb begin
        vld_pipe_d = '0;
        if (state_q != ST_IDLE || start) begin
            vld_pipe_d[0] = NPU_EN;
            for (int i = 1; i < IN_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    npu_ew_op u_op (
        .CLK   (CLK),
        .rst_x (rst_x),
        .acc   (accept),
        .op    (op_q),
        .a     (A_RDATA),
        .b     (B_RDATA),
        .vld_q (s1_vld),
        .raw_q (s1_raw)
    );

    always_comb begin
        s2_shr  = (op_q == OP_MUL) ? (s1_raw >>> shift_q) : s1_raw;
        lm_en_d = s1_vld;
        c_d     = s1_vld ? sat8(s2_shr) : c_q;
    end

    always_ff @(posedge CLK or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            vld_pipe_q <= '0;
            op_q       <= '0;
            shift_q    <= '0;
            acc_cnt_q  <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            lm_en_q    <= 1'b0;
            c_q        <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= NPU_EN;
            vld_pipe_q <= vld_pipe_d;
            op_q       <= op_d;
            shift_q    <= shift_d;
            acc_cnt_q  <= acc_cnt_d;
            out_cnt_q  <= out_cnt_d;
            done_q     <= done_d;
            lm_en_q    <= lm_en_d;
            c_q        <= c_d;
        end
    end

    assign LM_EN   = lm_en_q;
    assign C_WDATA = c_q;
    assign BUSY    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign DONE    = done_q;
endmodule
